// File: rtl/adder_select_scheduler_if.sv
// -----------------------------------------------------------------------------
// adder_select_scheduler_if
// Table write bus of the adder select scheduler.
//   wr_valid_i  : write request (master -> slave)
//   wr_ready_o  : write accepted when high together with wr_valid_i (slave -> master)
//   wr_addr_i   : table entry index
//   wr_mask_i   : adder select mask stored in the entry
//   wr_dwell_i  : hold time of the entry in cycles
// Modports: master (bench / host side), slave (scheduler side).
// -----------------------------------------------------------------------------
interface adder_select_scheduler_if #(
  parameter int N_ENTRIES   = 8,
  parameter int DWELL_WIDTH = 16,
  parameter int MASK_WIDTH  = 8
);
  localparam int AW = $clog2(N_ENTRIES);

  logic                   wr_valid_i;
  logic                   wr_ready_o;
  logic [AW-1:0]          wr_addr_i;
  logic [MASK_WIDTH-1:0]  wr_mask_i;
  logic [DWELL_WIDTH-1:0] wr_dwell_i;

  modport master (
    output wr_valid_i, wr_addr_i, wr_mask_i, wr_dwell_i,
    input  wr_ready_o
  );

  modport slave (
    input  wr_valid_i, wr_addr_i, wr_mask_i, wr_dwell_i,
    output wr_ready_o
  );
endinterface

// File: rtl/adder_select_scheduler.sv
// -----------------------------------------------------------------------------
// adder_select_scheduler
// Plays a table of (select mask, dwell) entries onto the select input of a
// conditional adder. Each entry is held for max(dwell,1) cycles, either as a
// single pass (ending with a one-cycle done pulse) or looping.
// Ports:
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   wr_bus          : table write bus (slave modport), accepted only in IDLE
//   run_i           : level, high runs the schedule, low aborts to IDLE
//   loop_i          : 1 = wrap to entry 0 after the last entry
//   n_entries_i     : active entries, values above N_ENTRIES clamp
//   add_select_o    : registered select mask
//   index_o         : entry currently applied
//   busy_o          : high while running
//   switch_o        : pulse in the first cycle of each applied entry
//   done_o          : pulse on single-pass completion
//   settle_o        : only with ADDER_SCHED_SETTLE_EN; high for two cycles
//                     starting at every switch_o pulse
// Optional feature macro: ADDER_SCHED_SETTLE_EN
// -----------------------------------------------------------------------------
module adder_select_scheduler #(
  parameter int N_ENTRIES   = 8,
  parameter int DWELL_WIDTH = 16,
  parameter int MASK_WIDTH  = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  adder_select_scheduler_if.slave       wr_bus,
  input  logic                          run_i,
  input  logic                          loop_i,
  input  logic [$clog2(N_ENTRIES):0]    n_entries_i,
  output logic [MASK_WIDTH-1:0]         add_select_o,
  output logic [$clog2(N_ENTRIES)-1:0]  index_o,
  output logic                          busy_o,
  output logic                          switch_o,
  output logic                          done_o
`ifdef ADDER_SCHED_SETTLE_EN
  ,
  output logic                          settle_o
`endif
);
  localparam int IW = $clog2(N_ENTRIES);
  localparam int NW = IW + 1;
  localparam logic [NW-1:0] N_MAX = NW'(N_ENTRIES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                 state_r;
  logic [MASK_WIDTH-1:0]  mask_tbl_r  [N_ENTRIES];
  logic [DWELL_WIDTH-1:0] dwell_tbl_r [N_ENTRIES];
  logic [DWELL_WIDTH-1:0] dwell_cnt_r;
  logic [MASK_WIDTH-1:0]  add_select_r;
  logic [IW-1:0]          index_r;
  logic                   busy_r;
  logic                   switch_r;
  logic                   done_r;
  logic                   wr_ready_r;

  logic [NW-1:0]          n_eff_s;
  logic [IW-1:0]          next_idx_s;
  logic                   last_s;
  logic                   has_entries_s;

  // The counter is loaded with hold-1 so that dwell 0 and dwell 1 both give a
  // single cycle and the all-ones dwell never needs an extra counter bit.
  function automatic logic [DWELL_WIDTH-1:0] hold_load(input logic [DWELL_WIDTH-1:0] d);
    if (d == DWELL_WIDTH'(0)) begin
      hold_load = DWELL_WIDTH'(0);
    end else begin
      hold_load = d - DWELL_WIDTH'(1);
    end
  endfunction

  // End-of-entry decision inputs: clamped entry count and "current is last".
  always_comb begin
    if (n_entries_i > N_MAX) begin
      n_eff_s = N_MAX;
    end else begin
      n_eff_s = n_entries_i;
    end
    next_idx_s    = index_r + IW'(1);
    // A count lowered below the current entry also ends the pass here.
    last_s        = (({1'b0, index_r} + NW'(1)) >= n_eff_s);
    has_entries_s = (n_eff_s != NW'(0));
  end

  // Schedule FSM, table write port and all registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r      <= IDLE;
      dwell_cnt_r  <= DWELL_WIDTH'(0);
      add_select_r <= MASK_WIDTH'(0);
      index_r      <= IW'(0);
      busy_r       <= 1'b0;
      switch_r     <= 1'b0;
      done_r       <= 1'b0;
      wr_ready_r   <= 1'b0;
      for (int i = 0; i < N_ENTRIES; i++) begin
        mask_tbl_r[i]  <= MASK_WIDTH'(0);
        dwell_tbl_r[i] <= DWELL_WIDTH'(0);
      end
    end else begin
      if (wr_bus.wr_valid_i && wr_ready_r) begin
        mask_tbl_r[wr_bus.wr_addr_i]  <= wr_bus.wr_mask_i;
        dwell_tbl_r[wr_bus.wr_addr_i] <= wr_bus.wr_dwell_i;
      end
      switch_r <= 1'b0;
      done_r   <= 1'b0;
      case (state_r)
        IDLE: begin
          if (run_i && has_entries_s) begin
            state_r      <= RUN;
            add_select_r <= mask_tbl_r[0];
            index_r      <= IW'(0);
            busy_r       <= 1'b1;
            switch_r     <= 1'b1;
            dwell_cnt_r  <= hold_load(dwell_tbl_r[0]);
            wr_ready_r   <= 1'b0;
          end else begin
            add_select_r <= MASK_WIDTH'(0);
            index_r      <= IW'(0);
            busy_r       <= 1'b0;
            dwell_cnt_r  <= DWELL_WIDTH'(0);
            wr_ready_r   <= 1'b1;
          end
        end
        RUN: begin
          if (!run_i) begin
            state_r      <= IDLE;
            add_select_r <= MASK_WIDTH'(0);
            index_r      <= IW'(0);
            busy_r       <= 1'b0;
            dwell_cnt_r  <= DWELL_WIDTH'(0);
            wr_ready_r   <= 1'b1;
          end else if (dwell_cnt_r != DWELL_WIDTH'(0)) begin
            dwell_cnt_r <= dwell_cnt_r - DWELL_WIDTH'(1);
          end else if (!last_s) begin
            add_select_r <= mask_tbl_r[next_idx_s];
            index_r      <= next_idx_s;
            switch_r     <= 1'b1;
            dwell_cnt_r  <= hold_load(dwell_tbl_r[next_idx_s]);
          end else if (loop_i && has_entries_s) begin
            add_select_r <= mask_tbl_r[0];
            index_r      <= IW'(0);
            switch_r     <= 1'b1;
            dwell_cnt_r  <= hold_load(dwell_tbl_r[0]);
          end else begin
            state_r      <= DONE;
            add_select_r <= MASK_WIDTH'(0);
            index_r      <= IW'(0);
            busy_r       <= 1'b0;
            done_r       <= 1'b1;
            dwell_cnt_r  <= DWELL_WIDTH'(0);
          end
        end
        DONE: begin
          state_r    <= IDLE;
          wr_ready_r <= 1'b1;
        end
        default: begin
          state_r      <= IDLE;
          add_select_r <= MASK_WIDTH'(0);
          index_r      <= IW'(0);
          busy_r       <= 1'b0;
          dwell_cnt_r  <= DWELL_WIDTH'(0);
          wr_ready_r   <= 1'b0;
        end
      endcase
    end
  end

  assign wr_bus.wr_ready_o = wr_ready_r;
  assign add_select_o      = add_select_r;
  assign index_o           = index_r;
  assign busy_o            = busy_r;
  assign switch_o          = switch_r;
  assign done_o            = done_r;

`ifdef ADDER_SCHED_SETTLE_EN
  logic apply_s;
  logic settle_r;
  logic settle_hold_r;

  // Asserted when the coming edge applies a new entry (same terms as switch_o).
  always_comb begin
    apply_s = 1'b0;
    case (state_r)
      IDLE:    apply_s = run_i && has_entries_s;
      RUN:     apply_s = run_i && (dwell_cnt_r == DWELL_WIDTH'(0)) &&
                         (!last_s || (loop_i && has_entries_s));
      default: apply_s = 1'b0;
    endcase
  end

  // Two-cycle settle window; a new switch restarts it, so short dwells chain.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      settle_r      <= 1'b0;
      settle_hold_r <= 1'b0;
    end else if (apply_s) begin
      settle_r      <= 1'b1;
      settle_hold_r <= 1'b1;
    end else if (settle_hold_r) begin
      settle_r      <= 1'b1;
      settle_hold_r <= 1'b0;
    end else begin
      settle_r      <= 1'b0;
      settle_hold_r <= 1'b0;
    end
  end

  assign settle_o = settle_r;
`endif
endmodule

// File: tb/tb_adder_select_scheduler.sv
// -----------------------------------------------------------------------------
// tb_adder_select_scheduler
// Randomized and directed bench with a behavioural schedule model; outputs are
// compared against the model on every falling edge. Directed scenarios pin the
// model with hand-computed sequences. Settle checks exist only when
// ADDER_SCHED_SETTLE_EN is defined.
// -----------------------------------------------------------------------------
module tb_adder_select_scheduler;
  localparam int N  = 8;
  localparam int DW = 8;
  localparam int MW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          run_s, loop_s;
  logic [3:0]    n_s;
  logic [MW-1:0] sel_s;
  logic [2:0]    idx_s;
  logic          busy_s, sw_s, done_s;
`ifdef ADDER_SCHED_SETTLE_EN
  logic          settle_s;
`endif

  int total = 0;
  int bad   = 0;

  // behavioural model state
  int        m_state, m_idx, m_left, m_settle, m_nc;
  logic [7:0] m_sel;
  bit        m_busy, m_sw, m_done, m_ready, m_wacc;
  int        m_mask [N];
  int        m_dwell[N];

  always #5 clk = ~clk;

  adder_select_scheduler_if #(.N_ENTRIES(N), .DWELL_WIDTH(DW), .MASK_WIDTH(MW)) bus ();

  adder_select_scheduler #(.N_ENTRIES(N), .DWELL_WIDTH(DW), .MASK_WIDTH(MW)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .wr_bus       (bus),
    .run_i        (run_s),
    .loop_i       (loop_s),
    .n_entries_i  (n_s),
    .add_select_o (sel_s),
    .index_o      (idx_s),
    .busy_o       (busy_s),
    .switch_o     (sw_s),
    .done_o       (done_s)
`ifdef ADDER_SCHED_SETTLE_EN
    ,
    .settle_o     (settle_s)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_apply(input int k);
    m_state  = 1;
    m_idx    = k;
    m_sel    = 8'(m_mask[k]);
    m_busy   = 1'b1;
    m_sw     = 1'b1;
    m_left   = ((m_dwell[k] < 1) ? 1 : m_dwell[k]) - 1;
    m_ready  = 1'b0;
    m_settle = 2;
  endtask

  // Model: advances once per rising edge, resets asynchronously.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_state = 0; m_idx = 0; m_left = 0; m_settle = 0; m_sel = 8'h00;
      m_busy = 1'b0; m_sw = 1'b0; m_done = 1'b0; m_ready = 1'b0;
      for (int i = 0; i < N; i++) begin
        m_mask[i] = 0;
        m_dwell[i] = 0;
      end
    end else begin
      m_nc   = (int'(n_s) > N) ? N : int'(n_s);
      m_wacc = bus.wr_valid_i && m_ready;
      m_sw   = 1'b0;
      m_done = 1'b0;
      if (m_settle > 0) m_settle--;
      case (m_state)
        0: begin
          if (run_s && m_nc != 0) m_apply(0);
          else m_ready = 1'b1;
        end
        1: begin
          if (!run_s) begin
            m_state = 0; m_sel = 8'h00; m_idx = 0; m_busy = 1'b0; m_ready = 1'b1; m_left = 0;
          end else if (m_left > 0) begin
            m_left--;
          end else if (m_idx + 1 < m_nc) begin
            m_apply(m_idx + 1);
          end else if (loop_s && m_nc != 0) begin
            m_apply(0);
          end else begin
            m_state = 2; m_sel = 8'h00; m_idx = 0; m_busy = 1'b0; m_done = 1'b1;
          end
        end
        default: begin
          m_state = 0;
          m_ready = 1'b1;
        end
      endcase
      if (m_wacc) begin
        m_mask[bus.wr_addr_i]  = int'(bus.wr_mask_i);
        m_dwell[bus.wr_addr_i] = int'(bus.wr_dwell_i);
      end
    end
  end

  // Compare process: every falling edge, DUT against model.
  initial forever begin
    @(negedge clk);
    chk("add_select", 32'(sel_s), 32'(m_sel));
    chk("index", 32'(idx_s), 32'(m_idx));
    chk("busy", 32'(busy_s), 32'(m_busy));
    chk("switch", 32'(sw_s), 32'(m_sw));
    chk("done", 32'(done_s), 32'(m_done));
    chk("wr_ready", 32'(bus.wr_ready_o), 32'(m_ready));
`ifdef ADDER_SCHED_SETTLE_EN
    chk("settle", 32'(settle_s), 32'(m_settle > 0));
`endif
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic wr(input int a, input int m, input int d);
    bus.wr_addr_i  = 3'(a);
    bus.wr_mask_i  = 8'(m);
    bus.wr_dwell_i = 8'(d);
    bus.wr_valid_i = 1'b1;
    @(negedge clk);
    bus.wr_valid_i = 1'b0;
  endtask

  logic [7:0] seq7  [7]  = '{8'h01, 8'h01, 8'h01, 8'h06, 8'h06, 8'hFF, 8'h00};
  logic [7:0] seq12 [12] = '{8'h01, 8'h01, 8'h01, 8'h06, 8'h06, 8'hFF,
                             8'h01, 8'h01, 8'h01, 8'h06, 8'h06, 8'hFF};
  logic       set13 [13] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1,
                             1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    int swc, dnc, cnt, len;
    rst_n = 1'b0; run_s = 1'b0; loop_s = 1'b0; n_s = 4'd0;
    bus.wr_valid_i = 1'b0; bus.wr_addr_i = 3'd0; bus.wr_mask_i = 8'h00; bus.wr_dwell_i = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_sel", 32'(sel_s), 32'h0);
    chk("reset_ready", 32'(bus.wr_ready_o), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 32'(bus.wr_ready_o), 32'h1);

    // single pass
    wr(0, 8'h01, 3); wr(1, 8'h06, 2); wr(2, 8'hFF, 0);
    n_s = 4'd3; loop_s = 1'b0; run_s = 1'b1;
    swc = 0; dnc = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("pass_seq", 32'(sel_s), 32'(seq7[i]));
      swc += int'(sw_s);
      dnc += int'(done_s);
      if (i == 6) run_s = 1'b0;
    end
    chk("pass_switches", 32'(swc), 32'd3);
    chk("pass_done", 32'(dnc), 32'd1);
    chk("pass_done_last", 32'(done_s), 32'h1);

    // looping, then stop
    @(negedge clk);
    loop_s = 1'b1; run_s = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("loop_seq", 32'(sel_s), 32'(seq12[i]));
      if (i == 11) run_s = 1'b0;
    end
    @(negedge clk);
    chk("stop_sel", 32'(sel_s), 32'h0);
    chk("stop_busy", 32'(busy_s), 32'h0);
    chk("stop_done", 32'(done_s), 32'h0);

    // write held during RUN stalls, lands in first IDLE cycle
    run_s = 1'b1;
    @(negedge clk);
    bus.wr_addr_i = 3'd0; bus.wr_mask_i = 8'hAA; bus.wr_dwell_i = 8'd1; bus.wr_valid_i = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("run_ready_low", 32'(bus.wr_ready_o), 32'h0);
    end
    run_s = 1'b0;
    @(negedge clk);
    chk("idle_ready_high", 32'(bus.wr_ready_o), 32'h1);
    @(negedge clk);
    bus.wr_valid_i = 1'b0;
    n_s = 4'd1; loop_s = 1'b0; run_s = 1'b1;
    @(negedge clk);
    chk("late_write_sel", 32'(sel_s), 32'hAA);
    chk("late_write_sw", 32'(sw_s), 32'h1);
    @(negedge clk);
    chk("late_write_done", 32'(done_s), 32'h1);
    run_s = 1'b0;
    @(negedge clk);

    // n=0 stays idle; n=12 clamps to 8
    n_s = 4'd0; run_s = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("n0_sel", 32'(sel_s), 32'h0);
      chk("n0_busy", 32'(busy_s), 32'h0);
    end
    run_s = 1'b0;
    for (int k = 3; k < 8; k++) wr(k, 8'h10 + k, 1);
    n_s = 4'd12; loop_s = 1'b0; run_s = 1'b1;
    swc = 0; dnc = 0;
    for (int i = 0; i < 50 && dnc == 0; i++) begin
      @(negedge clk);
      swc += int'(sw_s);
      dnc += int'(done_s);
    end
    run_s = 1'b0;
    chk("clamp_entries", 32'(swc), 32'd8);
    chk("clamp_done_seen", 32'(dnc), 32'd1);
    @(negedge clk);

    // asynchronous reset in the middle of entry 1
    wr(1, 8'h06, 10);
    n_s = 4'd3; loop_s = 1'b0; run_s = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_idx", 32'(idx_s), 32'h1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_sel", 32'(sel_s), 32'h0);
    chk("arst_idx", 32'(idx_s), 32'h0);
    chk("arst_busy", 32'(busy_s), 32'h0);
    chk("arst_done", 32'(done_s), 32'h0);
    chk("arst_ready", 32'(bus.wr_ready_o), 32'h0);
    run_s = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_arst_ready", 32'(bus.wr_ready_o), 32'h1);

    // full-scale dwell
    wr(0, 8'h5A, 8'hFF);
    n_s = 4'd1; loop_s = 1'b0; run_s = 1'b1;
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (sel_s == 8'h5A) cnt++;
      else if (cnt > 0) break;
    end
    run_s = 1'b0;
    chk("full_dwell", 32'(cnt), 32'd255);
    @(negedge clk);

`ifdef ADDER_SCHED_SETTLE_EN
    wr(0, 8'h01, 5); wr(1, 8'h02, 1); wr(2, 8'h04, 1);
    n_s = 4'd3; loop_s = 1'b1; run_s = 1'b1;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      chk("settle_seq", 32'(settle_s), 32'(set13[i]));
      if (i == 12) run_s = 1'b0;
    end
    @(negedge clk);
`endif

    // randomized traffic
    for (int it = 0; it < 200; it++) begin
      len = $urandom_range(0, 3);
      for (int w = 0; w < len; w++)
        wr($urandom_range(0, 7), $urandom_range(0, 255),
           ($urandom_range(0, 9) == 0) ? $urandom_range(0, 20) : $urandom_range(0, 3));
      n_s = 4'($urandom_range(0, 15));
      loop_s = 1'($urandom_range(0, 1));
      run_s = 1'b1;
      len = $urandom_range(1, 30);
      for (int c = 0; c < len; c++) begin
        @(negedge clk);
        if ($urandom_range(0, 9) == 0) n_s = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 9) == 0) loop_s = 1'($urandom_range(0, 1));
        bus.wr_valid_i = ($urandom_range(0, 7) == 0);
        bus.wr_addr_i  = 3'($urandom_range(0, 7));
        bus.wr_mask_i  = 8'($urandom_range(0, 255));
        bus.wr_dwell_i = 8'($urandom_range(0, 3));
      end
      bus.wr_valid_i = 1'b0;
      run_s = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      if ($urandom_range(0, 19) == 0) begin
        #1 rst_n = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
      end
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/adder_select_scheduler.md
ADDER_SELECT_SCHEDULER -- requirements
Module: adder_select_scheduler

Interface
REQ-001 Parameter N_ENTRIES, default 8, number of schedule table entries (power of two, 2..16).
REQ-002 Parameter DWELL_WIDTH, default 16, width of per-entry dwell count.
REQ-003 Parameter MASK_WIDTH, default 8, width of the adder select mask.
REQ-004 clk_i  in  1  sole clock; all logic on rising edge.
REQ-005 rst_ni  in  1  reset, asynchronous, active-low.
REQ-006 wr_valid_i  in  1  table write request.
REQ-007 wr_ready_o  out  1  table write accepted when high with wr_valid_i.
REQ-008 wr_addr_i  in  log2(N_ENTRIES)  table entry index.
REQ-009 wr_mask_i  in  MASK_WIDTH  select mask for the entry.
REQ-010 wr_dwell_i  in  DWELL_WIDTH  hold time of the entry, cycles.
REQ-011 run_i  in  1  level; high starts/continues the schedule, low stops it.
REQ-012 loop_i  in  1  1 = wrap to entry 0 after last entry; 0 = single pass.
REQ-013 n_entries_i  in  log2(N_ENTRIES)+1  active entries, 0..N_ENTRIES; values above N_ENTRIES clamp to N_ENTRIES.
REQ-014 add_select_o  out  MASK_WIDTH  registered select mask driving the conditional adder.
REQ-015 index_o  out  log2(N_ENTRIES)  entry currently applied.
REQ-016 busy_o  out  1  high in RUN state.
REQ-017 switch_o  out  1  one-cycle pulse in the first cycle a new add_select_o value is applied.
REQ-018 done_o  out  1  one-cycle pulse on single-pass completion.

Function
REQ-019 FSM states IDLE, RUN, DONE; all outputs registered.
REQ-020 wr_ready_o SHALL be 1 only in IDLE; a write completes on wr_valid_i & wr_ready_o, table updated the next edge; writes outside IDLE stall.
REQ-021 IDLE -> RUN when run_i=1 and n_entries_i!=0; next cycle add_select_o=mask[0], index_o=0, busy_o=1, switch_o=1.
REQ-022 run_i=1 with n_entries_i=0 SHALL keep IDLE, outputs unchanged.
REQ-023 Each entry held for max(dwell,1) cycles; dwell=0 treated as 1.
REQ-024 After the hold of entry k<n-1, entry k+1 applied the following cycle with switch_o=1.
REQ-025 After last entry (k=n-1): loop_i=1 -> entry 0 applied next cycle with switch_o=1; loop_i=0 -> DONE.
REQ-026 n_entries_i=1 with loop_i=1 SHALL re-apply entry 0 each dwell period, pulsing switch_o each time.
REQ-027 DONE lasts one cycle: add_select_o=0, busy_o=0, done_o=1; then IDLE.
REQ-028 run_i=0 in RUN SHALL force IDLE on the next edge with add_select_o=0, index_o=0, no done_o.
REQ-029 In IDLE add_select_o=0, index_o=0, switch_o=0.
REQ-030 loop_i and n_entries_i sampled at each end-of-entry decision; table contents are stable during RUN by REQ-020.
REQ-031 Dwell counter SHALL not overflow; full-scale dwell (all ones) holds 2^DWELL_WIDTH-1 cycles.

Reset
REQ-032 rst_ni low SHALL immediately force IDLE, add_select_o=0, index_o=0, busy_o=0, switch_o=0, done_o=0, wr_ready_o=0, dwell counter=0.
REQ-033 Table contents reset to mask=0, dwell=0.
REQ-034 wr_ready_o rises in the first cycle after rst_ni deasserts; reset mid-run aborts without done_o.

Configuration
REQ-035 Macro ADDER_SCHED_SETTLE_EN compiled in SHALL add output settle_o (1 bit), high for the 2 cycles starting with each switch_o pulse, covering the adder register latency; dwell <2 cycles keeps settle_o high until 2 cycles after the last switch.
REQ-036 Without ADDER_SCHED_SETTLE_EN, port settle_o and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-037 Write entries 0..2 = (0x01,3),(0x06,2),(0xFF,0); n=3, loop=0, run=1 -> add_select_o 0x01 x3, 0x06 x2, 0xFF x1, then 0x00 with done_o one cycle, switch_o 3 pulses.
REQ-038 Same table, loop=1, run held 12 cycles -> mask sequence repeats period 6; run=0 -> next cycle add_select_o=0, busy_o=0, no done_o.
REQ-039 wr_valid_i held during RUN -> wr_ready_o=0, table unchanged; write accepted first IDLE cycle after stop.
REQ-040 n_entries_i=0, run=1 -> stays IDLE, add_select_o=0; n_entries_i=12 (N_ENTRIES=8) -> 8 entries played.
REQ-041 rst_ni pulsed low mid-dwell of entry 1 -> outputs zero asynchronously, no done_o, wr_ready_o=1 first cycle after release.
REQ-042 With ADDER_SCHED_SETTLE_EN, dwell=(5,1,1) -> settle_o high cycles 0-1, then 5 to 8 continuous.
